// File: rtl/frame_builder.sv
// Frame builder: pulls PAYLOAD_LEN bytes from an upstream FIFO and emits
// preamble, sync word, payload and a modulo-256 checksum over a valid/ready link.
module frame_builder #(
    parameter int unsigned PAYLOAD_LEN = 10,
    parameter logic [7:0]  PREAMBLE    = 8'h55,
    parameter logic [7:0]  SYNC_WORD   = 8'hD5,
    parameter int unsigned GAP_CYCLES  = 4
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        input_ready,
    output logic        read_req,
    input  logic [7:0]  fifo_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic [15:0] frame_count
);

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SYNC,
        REQ,
        WAIT,
        SEND,
        CSUM,
        GAP
    } state_t;

    localparam logic [7:0] LEN_LAST = 8'(PAYLOAD_LEN);
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  checksum_q, checksum_d;
    logic [7:0]  byte_cnt_q, byte_cnt_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic        xfer;

    assign xfer = tx_valid_q && tx_ready;

    always_comb begin
        state_d       = state_q;
        tx_data_d     = tx_data_q;
        tx_valid_d    = tx_valid_q;
        checksum_d    = checksum_q;
        byte_cnt_d    = byte_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        frame_count_d = frame_count_q;
        case (state_q)
            IDLE: begin
                tx_valid_d = 1'b0;
                if (input_ready) begin
                    state_d    = PRE;
                    tx_valid_d = 1'b1;
                    tx_data_d  = PREAMBLE;
                end
            end
            PRE: begin
                if (xfer) begin
                    state_d   = SYNC;
                    tx_data_d = SYNC_WORD;
                end
            end
            SYNC: begin
                if (xfer) begin
                    state_d    = REQ;
                    tx_valid_d = 1'b0;
                    checksum_d = 8'h00;
                    byte_cnt_d = 8'h00;
                end
            end
            REQ: begin
                state_d = WAIT;
            end
            // The FIFO answers one cycle after read_req, so the byte is captured here.
            WAIT: begin
                state_d    = SEND;
                tx_data_d  = fifo_data;
                tx_valid_d = 1'b1;
                checksum_d = checksum_q + fifo_data;
                byte_cnt_d = byte_cnt_q + 8'd1;
            end
            SEND: begin
                if (xfer) begin
                    if (byte_cnt_q == LEN_LAST) begin
                        state_d   = CSUM;
                        tx_data_d = checksum_q;
                    end else begin
                        state_d    = REQ;
                        tx_valid_d = 1'b0;
                    end
                end
            end
            CSUM: begin
                if (xfer) begin
                    state_d       = GAP;
                    tx_valid_d    = 1'b0;
                    frame_count_d = frame_count_q + 16'd1;
                    gap_cnt_d     = 4'd0;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d    = IDLE;
                tx_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q       <= IDLE;
            tx_data_q     <= 8'h00;
            tx_valid_q    <= 1'b0;
            checksum_q    <= 8'h00;
            byte_cnt_q    <= 8'h00;
            gap_cnt_q     <= 4'd0;
            frame_count_q <= 16'h0000;
        end else begin
            state_q       <= state_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            checksum_q    <= checksum_d;
            byte_cnt_q    <= byte_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign read_req    = (state_q == REQ);
    assign busy        = (state_q != IDLE);
    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_frame_builder.sv
// Scoreboard bench for frame_builder: stimulus queues expected frame bytes,
// a negedge monitor pops and compares them on every tx transfer.
module tb_frame_builder;

    localparam int PAYLOAD_LEN = 10;

    logic        clk;
    logic        arst;
    logic        input_ready;
    logic        read_req;
    logic [7:0]  fifo_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic [15:0] frame_count;

    int compared = 0;
    int mismatched = 0;

    logic [7:0] exp_q[$];
    logic [7:0] fifo_q[$];

    int xfer_idx = 0;
    int rr_count = 0;
    int cyc = 0;
    int start_cyc = 0;
    int csum_cyc = 0;
    int last_len = 0;
    int last_gap = 0;
    int idle_run = 0;
    int last_idle = 0;
    logic prev_busy = 1'b0;
    logic prev_stall = 1'b0;
    logic prev_rr = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic stall_en = 1'b0;
    int stall_left = 0;
    int last_stall_idx = -1;

    frame_builder dut (
        .clk         (clk),
        .arst        (arst),
        .input_ready (input_ready),
        .read_req    (read_req),
        .fifo_data   (fifo_data),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .frame_count (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream FIFO model: answers a read request one cycle later.
    initial fifo_data = 8'h00;
    always @(posedge clk) begin
        if (read_req) begin
            if (fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
            else fifo_data <= 8'h00;
        end
    end

    // Downstream ready: stalls 5 cycles on the sync byte and on payload byte 4.
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!stall_en) last_stall_idx = -1;
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) tx_ready = 1'b1;
            end else if (stall_en && tx_valid && (xfer_idx == 1 || xfer_idx == 5)
                         && xfer_idx != last_stall_idx) begin
                tx_ready = 1'b0;
                stall_left = 5;
                last_stall_idx = xfer_idx;
            end
        end
    end

    // Monitor: scoreboard pops, stall hold, read_req spacing, frame/gap timing.
    always @(negedge clk) begin : monitor
        logic [7:0] e;
        cyc++;
        if (arst) begin
            xfer_idx = 0;
            prev_stall = 1'b0;
            prev_rr = 1'b0;
            prev_busy = 1'b0;
            idle_run = 0;
        end else begin
            if (read_req) begin
                rr_count++;
                compared++;
                if (prev_rr) begin
                    mismatched++;
                    $display("[TB] FAIL read_req_single: got back-to-back read_req, required single pulse");
                end
            end
            prev_rr = read_req;

            if (!busy) idle_run++;
            if (busy && !prev_busy) begin
                start_cyc = cyc;
                last_gap = cyc - csum_cyc - 1;
                last_idle = idle_run;
                idle_run = 0;
            end

            if (prev_stall) begin
                compared++;
                if (!tx_valid || tx_data != prev_data) begin
                    mismatched++;
                    $display("[TB] FAIL stall_hold: got valid=%0b data=%02h, required valid=1 data=%02h",
                             tx_valid, tx_data, prev_data);
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data = tx_data;

            if (tx_valid && tx_ready) begin
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL tx_unexpected: got %02h, required no transfer", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (tx_data != e) begin
                        mismatched++;
                        $display("[TB] FAIL tx_byte[%0d]: got %02h, required %02h", xfer_idx, tx_data, e);
                    end
                end
                if (xfer_idx == PAYLOAD_LEN + 2) begin
                    xfer_idx = 0;
                    csum_cyc = cyc;
                    last_len = cyc - start_cyc + 1;
                end else begin
                    xfer_idx++;
                end
            end
            prev_busy = busy;
        end
    end

    task automatic check_output(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] pl [PAYLOAD_LEN], input logic [7:0] csum);
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < PAYLOAD_LEN; i++) begin
            fifo_q.push_back(pl[i]);
            exp_q.push_back(pl[i]);
        end
        exp_q.push_back(csum);
    endtask

    task automatic wait_busy(input string name);
        int n = 0;
        while (!busy && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!busy) check_output({name, "_start_timeout"}, 0, 1);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0 || busy) check_output({name, "_done_timeout"}, 0, 1);
    endtask

    // One frame: raise input_ready until the frame starts, then drop it.
    task automatic run_frame(input string name);
        input_ready = 1'b1;
        wait_busy(name);
        input_ready = 1'b0;
        wait_done(name);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin : stimulus
        logic [7:0] p_inc [PAYLOAD_LEN];
        logic [7:0] p_ff  [PAYLOAD_LEN];
        logic [7:0] p_x10 [PAYLOAD_LEN];
        logic [7:0] p_lo  [PAYLOAD_LEN];
        logic [7:0] p_80  [PAYLOAD_LEN];
        int rr_base;
        int n;

        p_inc = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
        p_ff  = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        p_x10 = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80, 8'h90, 8'hA0};
        p_lo  = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
        p_80  = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};

        arst = 1'b1;
        input_ready = 1'b0;
        @(posedge clk);
        #1;
        check_output("rst_read_req", read_req, 0);
        check_output("rst_tx_valid", tx_valid, 0);
        check_output("rst_tx_data", tx_data, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_frame_count", frame_count, 0);
        @(posedge clk);
        #1;
        arst = 1'b0;

        // Basic frame: incrementing payload, checksum 0x37.
        apply_stimulus(p_inc, 8'h37);
        rr_base = rr_count;
        run_frame("f1");
        check_output("f1_read_reqs", rr_count - rr_base, 10);
        check_output("f1_frame_count", frame_count, 1);
        check_output("f1_length", last_len, 33);

        // All-0xFF payload: checksum wraps to 0xF6; idle afterwards with input_ready low.
        apply_stimulus(p_ff, 8'hF6);
        rr_base = rr_count;
        run_frame("f2");
        check_output("f2_read_reqs", rr_count - rr_base, 10);
        check_output("f2_frame_count", frame_count, 2);
        repeat (10) @(posedge clk);
        #1;
        check_output("f2_stays_idle", busy, 0);

        // Back-pressure on sync byte and payload byte 4.
        stall_en = 1'b1;
        apply_stimulus(p_x10, 8'h70);
        rr_base = rr_count;
        run_frame("f3");
        stall_en = 1'b0;
        check_output("f3_read_reqs", rr_count - rr_base, 10);
        check_output("f3_frame_count", frame_count, 3);
        check_output("f3_length_stalled", last_len, 43);

        // Two back-to-back frames with input_ready held high.
        apply_stimulus(p_lo, 8'h2D);
        apply_stimulus(p_80, 8'h00);
        rr_base = rr_count;
        input_ready = 1'b1;
        n = 0;
        while (exp_q.size() >= 13 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        input_ready = 1'b0;
        if (exp_q.size() >= 13) check_output("f4_second_start_timeout", 0, 1);
        wait_done("f4");
        check_output("f4_read_reqs", rr_count - rr_base, 20);
        check_output("f4_frame_count", frame_count, 5);
        check_output("f4_gap_cycles", last_gap, 5);
        check_output("f4_idle_cycles", last_idle, 1);
        check_output("f4_length", last_len, 33);

        // Reset during payload byte 6 aborts the frame.
        apply_stimulus(p_inc, 8'h37);
        input_ready = 1'b1;
        wait_busy("f5");
        input_ready = 1'b0;
        n = 0;
        while (!(tx_valid && xfer_idx == 7) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!(tx_valid && xfer_idx == 7)) check_output("f5_byte6_timeout", 0, 1);
        arst = 1'b1;
        #1;
        check_output("f5_rst_read_req", read_req, 0);
        check_output("f5_rst_tx_valid", tx_valid, 0);
        check_output("f5_rst_tx_data", tx_data, 0);
        check_output("f5_rst_busy", busy, 0);
        check_output("f5_rst_frame_count", frame_count, 0);
        exp_q.delete();
        fifo_q.delete();
        rr_base = rr_count;
        @(posedge clk);
        @(posedge clk);
        #1;
        arst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check_output("f5_no_read_after_rst", rr_count - rr_base, 0);
        check_output("f5_idle_after_rst", busy, 0);
        check_output("f5_count_after_rst", frame_count, 0);
        apply_stimulus(p_inc, 8'h37);
        run_frame("f6");
        check_output("f6_frame_count", frame_count, 1);

        // frame_count wrap: preset to 0xFFFE, then two frames.
        force dut.frame_count_q = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.frame_count_q;
        @(posedge clk);
        #1;
        check_output("wrap_preset", frame_count, 16'hFFFE);
        apply_stimulus(p_inc, 8'h37);
        run_frame("f7");
        check_output("wrap_top", frame_count, 16'hFFFF);
        apply_stimulus(p_ff, 8'hF6);
        run_frame("f8");
        check_output("wrap_zero", frame_count, 16'h0000);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
